// File: rtl/modo1_avaliador_tempo.sv
// modo1_avaliador_tempo: metronome unit divider plus held-note duration evaluator.
// Counts sixteenth-note units at the selected BPM and grades each released note against the expected length.
module modo1_avaliador_tempo #(
   parameter int DIV0 = 12500000,
   parameter int DIV1 = 8333333,
   parameter int DIV2 = 6250000,
   parameter int DIV3 = 5000000,
   parameter int TOL  = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       registra_bpm,
   input  logic [1:0] bpm_sel,
   input  logic       zeraMetro,
   input  logic       contaMetro,
   input  logic [3:0] duracao_esperada,
   input  logic       nota_feita,
   output logic       pulso_unidade,
   output logic       tempo_correto_baixo,
   output logic       tempo_correto,
   output logic       avaliado,
   output logic [3:0] unidades,
   output logic [1:0] db_estado
);
   localparam logic [1:0] OCIOSO = 2'd0, MEDINDO = 2'd1, AVALIADO = 2'd2;
   logic [1:0] bpm, estado, proximo;
   logic [23:0] contador, div;
   logic nota_d, subida, descida, fim;
   logic signed [4:0] diff;
   logic [4:0] mag;
   always_comb begin
      div = bpm == 2'd0 ? 24'(DIV0) : bpm == 2'd1 ? 24'(DIV1) : bpm == 2'd2 ? 24'(DIV2) : 24'(DIV3);
      // >= rather than == so a switch to a faster BPM never overshoots the wrap point
      fim = contador >= div - 24'd1;
      pulso_unidade = contaMetro & ~zeraMetro & fim;
      tempo_correto_baixo = contaMetro & (unidades >= duracao_esperada);
      subida = nota_feita & ~nota_d;
      descida = ~nota_feita & nota_d;
      diff = signed'({1'b0, unidades}) - signed'({1'b0, duracao_esperada});
      mag = diff[4] ? 5'(-diff) : 5'(diff);
      proximo = estado == OCIOSO   ? (subida ? MEDINDO : OCIOSO) :
                estado == MEDINDO  ? (descida ? AVALIADO : MEDINDO) :
                estado == AVALIADO ? (subida ? MEDINDO : AVALIADO) : OCIOSO;
      db_estado = estado;
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         bpm <= 2'd0;
         contador <= 24'd0;
         unidades <= 4'd0;
      end else begin
         if (registra_bpm) bpm <= bpm_sel;
         if (zeraMetro) begin
            contador <= 24'd0;
            unidades <= 4'd0;
         end else if (contaMetro) begin
            contador <= fim ? 24'd0 : contador + 24'd1;
            if (fim && unidades != 4'd15) unidades <= unidades + 4'd1;
         end
      end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         nota_d <= 1'b0;
         estado <= OCIOSO;
         tempo_correto <= 1'b0;
         avaliado <= 1'b0;
      end else begin
         nota_d <= nota_feita;
         estado <= proximo;
         avaliado <= estado == MEDINDO && descida;
         if (estado == MEDINDO && descida) tempo_correto <= mag <= 5'(TOL);
      end
endmodule

// File: tb/tb_modo1_avaliador_tempo.sv
// tb_modo1_avaliador_tempo: directed checks of divider, saturation, priority, evaluation, reset and BPM switch.
module tb_modo1_avaliador_tempo;
   logic clock = 1'b0, reset = 1'b1, registra_bpm = 1'b0, zeraMetro = 1'b0, contaMetro = 1'b0, nota_feita = 1'b0;
   logic [1:0] bpm_sel = 2'd0;
   logic [3:0] duracao_esperada = 4'd0;
   logic pulso_unidade, tempo_correto_baixo, tempo_correto, avaliado;
   logic [3:0] unidades;
   logic [1:0] db_estado;
   int total = 0, bad = 0, pcount = 0;
   logic last_p;
   logic [19:0] mask;
   always #5 clock = ~clock;
   modo1_avaliador_tempo #(.DIV0(4), .DIV1(3), .DIV2(2), .DIV3(1), .TOL(1)) dut (
      .clock(clock), .reset(reset), .registra_bpm(registra_bpm), .bpm_sel(bpm_sel),
      .zeraMetro(zeraMetro), .contaMetro(contaMetro), .duracao_esperada(duracao_esperada),
      .nota_feita(nota_feita), .pulso_unidade(pulso_unidade), .tempo_correto_baixo(tempo_correto_baixo),
      .tempo_correto(tempo_correto), .avaliado(avaliado), .unidades(unidades), .db_estado(db_estado));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic cyc();
      @(negedge clock);
      last_p = pulso_unidade;
      if (pulso_unidade) pcount++;
      @(posedge clock);
      #1;
   endtask
   task automatic load_bpm(input logic [1:0] b);
      registra_bpm = 1'b1; bpm_sel = b; contaMetro = 1'b0;
      cyc();
      registra_bpm = 1'b0;
   endtask
   task automatic zera();
      zeraMetro = 1'b1; contaMetro = 1'b0;
      cyc();
      zeraMetro = 1'b0;
   endtask
   task automatic press(input int n);
      zera();
      nota_feita = 1'b1; contaMetro = 1'b1;
      repeat (n) cyc();
      nota_feita = 1'b0; contaMetro = 1'b0;
      cyc();
   endtask
   initial begin
      #2;
      chk("rst_unid", 32'(unidades), 0);
      chk("rst_est", 32'(db_estado), 0);
      chk("rst_tc", 32'(tempo_correto), 0);
      chk("rst_aval", 32'(avaliado), 0);
      chk("rst_pulso", 32'(pulso_unidade), 0);
      @(posedge clock); #1;
      reset = 1'b0;
      load_bpm(2'd0);
      zera();
      contaMetro = 1'b1; pcount = 0;
      for (int i = 0; i < 20; i++) begin cyc(); mask[i] = last_p; end
      chk("div0_mask", 32'(mask), 32'h88888);
      chk("div0_unid", 32'(unidades), 5);
      load_bpm(2'd3);
      zera();
      contaMetro = 1'b1; pcount = 0;
      repeat (20) cyc();
      chk("sat_unid", 32'(unidades), 15);
      chk("sat_pulses", 32'(pcount), 20);
      zeraMetro = 1'b1; contaMetro = 1'b1; pcount = 0;
      repeat (3) cyc();
      chk("prio_pulses", 32'(pcount), 0);
      chk("prio_unid", 32'(unidades), 0);
      zeraMetro = 1'b0; contaMetro = 1'b0;
      load_bpm(2'd1);
      duracao_esperada = 4'd4;
      zera();
      nota_feita = 1'b1; contaMetro = 1'b1;
      repeat (15) cyc();
      chk("ev5_unid", 32'(unidades), 5);
      chk("ev5_est", 32'(db_estado), 1);
      chk("ev5_baixo", 32'(tempo_correto_baixo), 1);
      nota_feita = 1'b0; contaMetro = 1'b0;
      cyc();
      chk("ev5_aval", 32'(avaliado), 1);
      chk("ev5_tc", 32'(tempo_correto), 1);
      chk("ev5_est2", 32'(db_estado), 2);
      cyc();
      chk("ev5_aval_off", 32'(avaliado), 0);
      chk("ev5_tc_hold", 32'(tempo_correto), 1);
      press(21);
      chk("ev7_unid", 32'(unidades), 7);
      chk("ev7_aval", 32'(avaliado), 1);
      chk("ev7_tc", 32'(tempo_correto), 0);
      press(6);
      chk("ev2_unid", 32'(unidades), 2);
      chk("ev2_tc", 32'(tempo_correto), 0);
      press(9);
      chk("ev3_unid", 32'(unidades), 3);
      chk("ev3_tc", 32'(tempo_correto), 1);
      duracao_esperada = 4'd0; contaMetro = 1'b1;
      #1;
      chk("zero_baixo", 32'(tempo_correto_baixo), 1);
      contaMetro = 1'b0;
      #1;
      chk("zero_baixo_off", 32'(tempo_correto_baixo), 0);
      duracao_esperada = 4'd4;
      zera();
      nota_feita = 1'b1; contaMetro = 1'b1;
      repeat (4) cyc();
      chk("mid_est", 32'(db_estado), 1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_est", 32'(db_estado), 0);
      chk("mid_rst_tc", 32'(tempo_correto), 0);
      nota_feita = 1'b0; contaMetro = 1'b0;
      cyc();
      chk("mid_rst_aval", 32'(avaliado), 0);
      reset = 1'b0;
      cyc();
      chk("post_rst_aval", 32'(avaliado), 0);
      load_bpm(2'd1);
      press(15);
      chk("post_rst_unid", 32'(unidades), 5);
      chk("post_rst_ev", 32'(avaliado), 1);
      chk("post_rst_tc", 32'(tempo_correto), 1);
      load_bpm(2'd0);
      zera();
      contaMetro = 1'b1; pcount = 0;
      repeat (3) cyc();
      chk("sw_pre_pulses", 32'(pcount), 0);
      load_bpm(2'd2);
      contaMetro = 1'b1; mask = '0;
      for (int i = 0; i < 5; i++) begin cyc(); mask[i] = last_p; end
      chk("sw_mask", 32'(mask), 32'h15);
      chk("sw_unid", 32'(unidades), 3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/modo1_avaliador_tempo.md
MODO1_AVALIADOR_TEMPO -- requirements
Module: modo1_avaliador_tempo

Interface
REQ-001 Parameter DIV0, default 12500000, clock cycles per sixteenth-note unit at BPM option 0 (60 BPM @ 50 MHz); SHALL be >= 1.
REQ-002 Parameter DIV1, default 8333333, cycles per unit at BPM option 1 (90 BPM); SHALL be >= 1.
REQ-003 Parameter DIV2, default 6250000, cycles per unit at BPM option 2 (120 BPM); SHALL be >= 1.
REQ-004 Parameter DIV3, default 5000000, cycles per unit at BPM option 3 (150 BPM); SHALL be >= 1.
REQ-005 Parameter TOL, default 1, accepted absolute deviation, in units, between held and expected duration.
REQ-006 clock  input  1  system clock; all state SHALL change on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 registra_bpm  input  1  loads bpm_sel into the BPM register.
REQ-009 bpm_sel  input  2  BPM option from the menu.
REQ-010 zeraMetro  input  1  clears the divider and unit counter.
REQ-011 contaMetro  input  1  enables the divider.
REQ-012 duracao_esperada  input  4  expected note duration in units, from the song memory.
REQ-013 nota_feita  input  1  level, high while any key is held.
REQ-014 pulso_unidade  output  1  one-cycle pulse at every unit boundary.
REQ-015 tempo_correto_baixo  output  1  expected duration reached.
REQ-016 tempo_correto  output  1  last held note was within tolerance.
REQ-017 avaliado  output  1  one-cycle pulse when tempo_correto is updated.
REQ-018 unidades  output  4  current unit count.
REQ-019 db_estado  output  2  current FSM state.

Function
REQ-020 BPM register (2 b) SHALL load bpm_sel on any edge where registra_bpm=1 and hold otherwise; the active divisor is DIV[bpm register].
REQ-021 Divider counter (24 b): zeraMetro=1 -> 0; else if contaMetro=1 -> counter == DIV-1 ? 0 : counter+1; else hold.
REQ-022 zeraMetro SHALL have priority over contaMetro in every cycle.
REQ-023 pulso_unidade SHALL be 1 exactly in cycles where contaMetro=1, zeraMetro=0 and counter == DIV-1.
REQ-024 unidades SHALL increment on each pulso_unidade, saturate at 15, and clear on zeraMetro.
REQ-025 A BPM change mid-count SHALL apply immediately; if counter >= new DIV-1, the next counting cycle SHALL produce the pulse and wrap to 0.
REQ-026 tempo_correto_baixo SHALL be combinational: 1 when contaMetro=1 and unidades >= duracao_esperada, else 0; with duracao_esperada=0 it SHALL be 1 whenever contaMetro=1.
REQ-027 nota_feita SHALL be registered once (nota_d); subida = nota_feita & ~nota_d; descida = ~nota_feita & nota_d.
REQ-028 The FSM SHALL have states OCIOSO=0, MEDINDO=1, AVALIADO=2; encoding 3 is illegal and SHALL go to OCIOSO.
REQ-029 OCIOSO -> MEDINDO on subida; otherwise stay.
REQ-030 MEDINDO -> AVALIADO on descida; otherwise stay.
REQ-031 AVALIADO -> MEDINDO on subida; otherwise stay.
REQ-032 On the MEDINDO->AVALIADO edge, tempo_correto SHALL load (|unidades - duracao_esperada| <= TOL) using pre-edge values, computed at 5-bit signed width without wrap; avaliado=1 in the following cycle only.
REQ-033 tempo_correto SHALL be valid and stable from the cycle after descida until the next evaluation; it is the state after toca_nota in the control FSM.
REQ-034 If zeraMetro and descida coincide, the evaluation SHALL use the pre-clear unidades, and the counters SHALL still clear.
REQ-035 subida in MEDINDO (impossible after registering) SHALL be ignored; zeraMetro SHALL not affect FSM state or tempo_correto.

Reset
REQ-036 On reset, the following SHALL be 0: BPM register, divider, unidades, nota_d, tempo_correto, avaliado and pulso_unidade; the FSM SHALL be OCIOSO.
REQ-037 Reset asserted mid-measurement SHALL abort it with no avaliado pulse; normal operation SHALL resume on the first edge after release.

Verification (DIV0=4, DIV1=3, DIV2=2, DIV3=1, TOL=1)
REQ-038 Divider: bpm_sel=0 loaded, contaMetro=1 for 20 cycles -> pulso_unidade in cycles 4, 8, 12, 16, 20 and unidades=5; with bpm 3, 20 cycles -> saturates at 15.
REQ-039 Priority: contaMetro=1 and zeraMetro=1 together for 3 cycles -> counter=0, unidades=0, no pulse.
REQ-040 Evaluation: bpm 1, duracao_esperada=4; zeraMetro pulse, then nota_feita high with contaMetro=1 for 15 cycles (unidades=5), then low -> avaliado pulse and tempo_correto=1; repeat with a 21-cycle hold (unidades=7) -> tempo_correto=0.
REQ-041 Lower edge and zero: duracao_esperada=4, release at unidades=3 -> tempo_correto=1; release at unidades=2 -> 0; duracao_esperada=0 with contaMetro=1 -> tempo_correto_baixo=1 immediately.
REQ-042 Reset mid-hold: assert reset with FSM in MEDINDO -> db_estado=0, tempo_correto=0, no avaliado; the next full press is evaluated normally.
REQ-043 BPM switch: bpm 0 with counter=3, load bpm 2 -> pulse in the next counting cycle, then a pulse every 2 cycles.
